// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences fetch, decode,
// execute, memory and write-back for one instruction at a time.
//
// Handshake: mem_read/mem_write are held for as long as the FSM sits in FETCH or MEM.
// mem_ready=1 in such a cycle completes the access at the next rising edge.
// mem_ready is ignored in every other state.
module multicycle_ctrl #(
  parameter int COUNT_W     = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         opcode,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               busy,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               alu_src,
  output logic [1:0]         alu_op,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               halted,
  output logic               error,
  output logic [COUNT_W-1:0] retired,
  output logic [2:0]         dbg_state
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_R    = 3'd1;
  localparam logic [2:0] C_LW   = 3'd2;
  localparam logic [2:0] C_SW   = 3'd3;
  localparam logic [2:0] C_BEQ  = 3'd4;
  localparam logic [2:0] C_ADDI = 3'd5;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic [2:0]         state_q, state_d;
  logic [2:0]         cls_q, cls_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [COUNT_W-1:0] retired_q, retired_d;
  logic               halted_q, halted_d;
  logic               error_q, error_d;
  logic               wait_expired;

  // Ready on the limit cycle still wins; only a missing ready at the limit aborts.
  assign wait_expired = (wait_q == WAIT_W'(MEM_TIMEOUT));

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    wait_d     = wait_q;
    retired_d  = retired_q;
    halted_d   = 1'b0;
    error_d    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        cls_d   = C_NONE;
        state_d = S_EXEC;
        case (opcode)
          OP_R:    cls_d = C_R;
          OP_LW:   cls_d = C_LW;
          OP_SW:   cls_d = C_SW;
          OP_BEQ:  cls_d = C_BEQ;
          OP_ADDI: cls_d = C_ADDI;
          OP_J: begin
            pc_write  = 1'b1;
            pc_src    = 2'b10;
            retired_d = retired_q + 1'b1;
            wait_d    = '0;
            state_d   = S_FETCH;
          end
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = S_IDLE;
          end
          default: begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_R: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          C_ADDI: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          C_LW, C_SW: begin
            alu_src = 1'b1;
            wait_d  = '0;
            state_d = S_MEM;
          end
          C_BEQ: begin
            alu_op = 2'b01;
            if (alu_zero) begin
              pc_write = 1'b1;
              pc_src   = 2'b01;
            end
            retired_d = retired_q + 1'b1;
            wait_d    = '0;
            state_d   = S_FETCH;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_MEM: begin
        mem_read  = (cls_q == C_LW);
        mem_write = (cls_q == C_SW);
        if (mem_ready) begin
          if (cls_q == C_LW) begin
            state_d = S_WB;
          end else begin
            retired_d = retired_q + 1'b1;
            wait_d    = '0;
            state_d   = S_FETCH;
          end
        end else if (wait_expired) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (cls_q == C_R);
        mem_to_reg = (cls_q == C_LW);
        retired_d  = retired_q + 1'b1;
        wait_d     = '0;
        state_d    = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cls_q     <= C_NONE;
      wait_q    <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      error_q   <= error_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign halted    = halted_q;
  assign error     = error_q;
  assign retired   = retired_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds a per-cycle stimulus/expectation trace from
// instruction-level rules, then replays it against the DUT cycle by cycle.
module tb_multicycle_ctrl;

  localparam int CW = 4;
  localparam int TO = 6;
  localparam int W  = 15 + CW;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
  } strb_t;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic [5:0] op;
    logic       rdy;
    logic       z;
  } stim_t;

  typedef struct {
    logic [5:0] op;
    int         df;
    int         dm;
    logic       z;
    int         ab;
  } ins_t;

  logic          clk = 1'b0;
  logic          reset, start, alu_zero, mem_ready;
  logic [5:0]    opcode;
  logic          busy, pc_write, ir_write, mem_read, mem_write, alu_src;
  logic          reg_dst, reg_write, mem_to_reg, halted, error;
  logic [1:0]    pc_src, alu_op;
  logic [CW-1:0] retired;
  logic [2:0]    dbg_state;

  stim_t         stim_q[$];
  logic [W-1:0]  exp_q[$];
  ins_t          prog_q[$];
  logic [CW-1:0] m_ret;
  logic          pend_halt, pend_err;
  int            n_checks, n_fail;

  multicycle_ctrl #(.COUNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .busy(busy),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .alu_op(alu_op), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .halted(halted), .error(error),
    .retired(retired), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] ro();
    return 6'($urandom());
  endfunction

  // ---------------- reference model: trace builder ----------------
  task automatic push(input logic rst, input logic st, input logic [5:0] op,
                      input logic rdy, input logic z, input logic bsy, input strb_t s);
    stim_t t;
    t = '{rst: rst, start: st, op: op, rdy: rdy, z: z};
    stim_q.push_back(t);
    exp_q.push_back({bsy, s, pend_halt, pend_err, m_ret});
    pend_halt = 1'b0;
    pend_err  = 1'b0;
  endtask

  task automatic model_reset();
    m_ret     = '0;
    pend_halt = 1'b0;
    pend_err  = 1'b0;
  endtask

  task automatic idle(input int n);
    strb_t s;
    s = '0;
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, ro(), rb(), rb(), 1'b0, s);
  endtask

  task automatic push_reset(input logic st);
    strb_t s;
    s = '0;
    push(1'b1, st, ro(), rb(), rb(), 1'b0, s);
    model_reset();
  endtask

  // res: 0 = access completed, 1 = timed out, 2 = aborted by reset
  task automatic do_wait(input int d, input bit fetch, input bit lw, input int abort_at,
                         output int res);
    int n;
    strb_t s;
    logic rdy;
    n   = (d > TO) ? TO + 1 : d + 1;
    res = (d > TO) ? 1 : 0;
    for (int i = 0; i < n; i++) begin
      rdy = (i == d);
      s = '0;
      if (fetch) begin
        s.mem_read = 1'b1;
        s.ir_write = rdy;
        s.pc_write = rdy;
      end else begin
        s.mem_read  = lw;
        s.mem_write = !lw;
      end
      if (i == abort_at) begin
        push(1'b1, rb(), ro(), rdy, rb(), 1'b1, s);
        model_reset();
        res = 2;
        return;
      end
      push(1'b0, rb(), ro(), rdy, rb(), 1'b1, s);
    end
    if (res == 1) pend_err = 1'b1;
  endtask

  task automatic gen_instr(input ins_t in, output bit cont);
    int r;
    strb_t s;
    bit is_r, is_lw, is_sw, is_beq, is_addi, is_j;
    cont    = 1'b0;
    is_r    = (in.op == 6'b000000);
    is_lw   = (in.op == 6'b100011);
    is_sw   = (in.op == 6'b101011);
    is_beq  = (in.op == 6'b000100);
    is_addi = (in.op == 6'b001000);
    is_j    = (in.op == 6'b000010);
    do_wait(in.df, 1'b1, 1'b0, -1, r);
    if (r != 0) return;
    s = '0;
    if (is_j) begin
      s.pc_write = 1'b1;
      s.pc_src   = 2'b10;
    end
    push(1'b0, rb(), in.op, rb(), rb(), 1'b1, s);
    if (is_j) begin
      m_ret = m_ret + 1'b1;
      cont  = 1'b1;
      return;
    end
    if (!(is_r || is_lw || is_sw || is_beq || is_addi)) begin
      if (in.op == 6'b111111) pend_halt = 1'b1;
      else pend_err = 1'b1;
      return;
    end
    s = '0;
    if (is_r) s.alu_op = 2'b10;
    else if (is_beq) begin
      s.alu_op   = 2'b01;
      s.pc_write = in.z;
      s.pc_src   = in.z ? 2'b01 : 2'b00;
    end else s.alu_src = 1'b1;
    push(1'b0, rb(), ro(), rb(), in.z, 1'b1, s);
    if (is_beq) begin
      m_ret = m_ret + 1'b1;
      cont  = 1'b1;
      return;
    end
    if (is_lw || is_sw) begin
      do_wait(in.dm, 1'b0, is_lw, in.ab, r);
      if (r != 0) return;
      if (is_sw) begin
        m_ret = m_ret + 1'b1;
        cont  = 1'b1;
        return;
      end
    end
    s = '0;
    s.reg_write  = 1'b1;
    s.reg_dst    = is_r;
    s.mem_to_reg = is_lw;
    push(1'b0, rb(), ro(), rb(), rb(), 1'b1, s);
    m_ret = m_ret + 1'b1;
    cont  = 1'b1;
  endtask

  task automatic add(input logic [5:0] op, input int df, input int dm, input logic z, input int ab);
    ins_t in;
    in = '{op: op, df: df, dm: dm, z: z, ab: ab};
    prog_q.push_back(in);
  endtask

  // Start from IDLE, run prog_q; a program still running at its end is closed by HALT.
  task automatic run_prog();
    strb_t s;
    ins_t in;
    bit cont;
    s = '0;
    push(1'b0, 1'b1, ro(), rb(), rb(), 1'b0, s);
    cont = 1'b1;
    while (prog_q.size() > 0 && cont) begin
      in = prog_q.pop_front();
      gen_instr(in, cont);
    end
    prog_q.delete();
    if (cont) begin
      in = '{op: 6'b111111, df: 0, dm: 0, z: 1'b0, ab: -1};
      gen_instr(in, cont);
    end
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ill[3];
    ill[0] = 6'b111110;
    ill[1] = 6'b000001;
    ill[2] = 6'b100000;
    case ($urandom_range(0, 8))
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b001000;
      5, 6: return 6'b000010;
      7: return 6'b111111;
      default: return ill[$urandom_range(0, 2)];
    endcase
  endfunction

  function automatic int rand_delay();
    if ($urandom_range(0, 9) == 0) return TO + int'($urandom_range(0, 1));
    return int'($urandom_range(0, 2));
  endfunction

  task automatic build();
    model_reset();
    add(6'b000000, 0, 0, 1'b0, -1); run_prog(); idle(1);
    add(6'b100011, 3, 3, 1'b0, -1); run_prog(); idle(1);
    add(6'b000100, 0, 0, 1'b1, -1); add(6'b000100, 0, 0, 1'b0, -1); run_prog(); idle(1);
    push_reset(1'b0);
    for (int i = 0; i < 16; i++) add(6'b000010, 0, 0, 1'b0, -1);
    run_prog(); idle(1);
    add(6'b101011, 0, TO + 1, 1'b0, -1); run_prog(); idle(1);
    add(6'b111110, 0, 0, 1'b0, -1); run_prog(); idle(1);
    add(6'b001000, TO, 0, 1'b0, -1); add(6'b100011, 1, TO, 1'b0, -1); run_prog(); idle(1);
    add(6'b001000, TO + 1, 0, 1'b0, -1); run_prog(); idle(1);
    add(6'b000000, 0, 0, 1'b0, -1); add(6'b100011, 0, 3, 1'b0, 1); run_prog(); idle(2);
    push_reset(1'b1); idle(1);
    add(6'b111111, 0, 0, 1'b0, -1); run_prog();
    add(6'b000000, 0, 0, 1'b0, -1); run_prog(); idle(1);
    for (int p = 0; p < 40; p++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++)
        add(rand_op(), rand_delay(), rand_delay(), rb(), -1);
      run_prog();
      idle(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    stim_t t;
    logic [W-1:0] got;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    start     = 1'b1;
    opcode    = '0;
    alu_zero  = 1'b0;
    mem_ready = 1'b1;
    build();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    got = {busy, pc_write, pc_src, ir_write, mem_read, mem_write, alu_src, alu_op,
           reg_dst, reg_write, mem_to_reg, halted, error, retired};
    check("reset", got, '0);
    for (int i = 0; i < stim_q.size(); i++) begin
      @(posedge clk);
      #1;
      t         = stim_q[i];
      reset     = t.rst;
      start     = t.start;
      opcode    = t.op;
      mem_ready = t.rdy;
      alu_zero  = t.z;
      @(negedge clk);
      got = {busy, pc_write, pc_src, ir_write, mem_read, mem_write, alu_src, alu_op,
             reg_dst, reg_write, mem_to_reg, halted, error, retired};
      check($sformatf("cyc%0d", i), got, exp_q[i]);
    end
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
